// File: rtl/cache_eviction_controller.sv
`default_nettype none
// ============================================================================
// cache_eviction_controller: hit/miss sequencing for one set, covering victim
// selection, dirty writeback, line fill and allocation.
// Optional policy-wait abort when EVICT_TIMEOUT_EN is defined.  Rev 1.0
// ============================================================================
module cache_eviction_controller #(
  parameter int NUM_WAYS      = 8,
  parameter int EVICT_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  input  logic                req_write_i,
  output logic                req_ready_o,
  input  logic [NUM_WAYS-1:0] hit_way_i,
  input  logic [NUM_WAYS-1:0] way_valid_i,
  input  logic [NUM_WAYS-1:0] way_dirty_i,
  input  logic [NUM_WAYS-1:0] eviction_target_i,
  input  logic                eviction_ready_i,
  output logic [NUM_WAYS-1:0] access_way_o,
  output logic [NUM_WAYS-1:0] alloc_way_o,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic [NUM_WAYS-1:0] wb_way_o,
  output logic                fill_valid_o,
  input  logic                fill_ready_i,
  input  logic                fill_done_i,
  output logic                resp_valid_o,
  output logic                resp_hit_o,
  output logic                resp_err_o,
  output logic [NUM_WAYS-1:0] resp_way_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_SELECT    = 3'd2,
    S_WRITEBACK = 3'd3,
    S_FILL      = 3'd4,
    S_ALLOC     = 3'd5,
    S_RESP      = 3'd6
  } state_t;

  localparam logic [NUM_WAYS-1:0] c_ONE = NUM_WAYS'(1);

  state_t              state_q;
  logic [NUM_WAYS-1:0] victim_q;
  logic [NUM_WAYS-1:0] access_q;
  logic [NUM_WAYS-1:0] alloc_q;
  logic [NUM_WAYS-1:0] wb_way_q;
  logic [NUM_WAYS-1:0] resp_way_q;
  logic                req_ready_q;
  logic                req_write_q;
  logic                wb_valid_q;
  logic                fill_valid_q;
  logic                fill_hs_q;
  logic                resp_valid_q;
  logic                resp_hit_q;

  // x & -x isolates the lowest set bit, giving lowest-index priority
  logic [NUM_WAYS-1:0] w_hit_low;
  logic [NUM_WAYS-1:0] w_inv;
  logic [NUM_WAYS-1:0] w_inv_low;
  logic [NUM_WAYS-1:0] w_tgt_low;
  logic                w_tgt_dirty;
  logic                w_fill_hs;
  logic                w_fill_ok;
  logic                w_unused_write;

  assign w_hit_low      = hit_way_i & (~hit_way_i + c_ONE);
  assign w_inv          = ~way_valid_i;
  assign w_inv_low      = w_inv & (~w_inv + c_ONE);
  assign w_tgt_low      = eviction_target_i & (~eviction_target_i + c_ONE);
  assign w_tgt_dirty    = |(w_tgt_low & way_dirty_i & way_valid_i);
  assign w_fill_hs      = fill_valid_q & fill_ready_i;
  assign w_fill_ok      = (fill_hs_q | w_fill_hs) & fill_done_i;
  assign w_unused_write = req_write_q;

`ifdef EVICT_TIMEOUT_EN
  localparam int c_CW = $clog2(EVICT_TIMEOUT + 1);
  logic [c_CW-1:0] tmo_q;
  logic            resp_err_q;
  logic            w_tmo_hit;
  assign w_tmo_hit  = (tmo_q == c_CW'(EVICT_TIMEOUT - 1));
  assign resp_err_o = resp_err_q;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (EVICT_TIMEOUT > 0);
  assign resp_err_o   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      victim_q     <= '0;
      access_q     <= '0;
      alloc_q      <= '0;
      wb_way_q     <= '0;
      resp_way_q   <= '0;
      req_ready_q  <= 1'b1;
      req_write_q  <= 1'b0;
      wb_valid_q   <= 1'b0;
      fill_valid_q <= 1'b0;
      fill_hs_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
`ifdef EVICT_TIMEOUT_EN
      tmo_q        <= '0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      access_q     <= '0;
      alloc_q      <= '0;
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            req_write_q <= req_write_i;
            req_ready_q <= 1'b0;
            state_q     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (|hit_way_i) begin
            victim_q     <= w_hit_low;
            access_q     <= w_hit_low;
            resp_valid_q <= 1'b1;
            resp_hit_q   <= 1'b1;
            resp_way_q   <= w_hit_low;
            state_q      <= S_RESP;
          end else begin
`ifdef EVICT_TIMEOUT_EN
            tmo_q        <= '0;
`endif
            state_q      <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (|w_inv) begin
            victim_q     <= w_inv_low;
            fill_valid_q <= 1'b1;
            fill_hs_q    <= 1'b0;
            state_q      <= S_FILL;
          end else if (eviction_ready_i && (|eviction_target_i)) begin
            victim_q <= w_tgt_low;
            if (w_tgt_dirty) begin
              wb_valid_q <= 1'b1;
              wb_way_q   <= w_tgt_low;
              state_q    <= S_WRITEBACK;
            end else begin
              fill_valid_q <= 1'b1;
              fill_hs_q    <= 1'b0;
              state_q      <= S_FILL;
            end
          end
`ifdef EVICT_TIMEOUT_EN
          else if (w_tmo_hit) begin
            resp_valid_q <= 1'b1;
            resp_hit_q   <= 1'b0;
            resp_err_q   <= 1'b1;
            resp_way_q   <= '0;
            state_q      <= S_RESP;
          end else begin
            tmo_q <= tmo_q + c_CW'(1);
          end
`endif
        end
        S_WRITEBACK: begin
          if (wb_ready_i) begin
            wb_valid_q   <= 1'b0;
            wb_way_q     <= '0;
            fill_valid_q <= 1'b1;
            fill_hs_q    <= 1'b0;
            state_q      <= S_FILL;
          end
        end
        S_FILL: begin
          if (w_fill_hs) begin
            fill_valid_q <= 1'b0;
            fill_hs_q    <= 1'b1;
          end
          if (w_fill_ok) begin
            alloc_q   <= victim_q;
            fill_hs_q <= 1'b0;
            state_q   <= S_ALLOC;
          end
        end
        S_ALLOC: begin
          resp_valid_q <= 1'b1;
          resp_hit_q   <= 1'b0;
          resp_way_q   <= victim_q;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          resp_hit_q  <= 1'b0;
          resp_way_q  <= '0;
`ifdef EVICT_TIMEOUT_EN
          resp_err_q  <= 1'b0;
`endif
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign access_way_o = access_q;
  assign alloc_way_o  = alloc_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_way_o     = wb_way_q;
  assign fill_valid_o = fill_valid_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_hit_o   = resp_hit_q;
  assign resp_way_o   = resp_way_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_eviction_controller.sv
`default_nettype none
// ============================================================================
// tb_cache_eviction_controller: directed scenarios with a response scoreboard.
// Timeout scenario follows EVICT_TIMEOUT_EN.  Rev 1.0
// ============================================================================
module tb_cache_eviction_controller;
  localparam int NW  = 8;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_write, req_ready;
  logic [NW-1:0] hit_way, way_valid, way_dirty, ev_target;
  logic          ev_ready;
  logic [NW-1:0] access_way, alloc_way, wb_way, resp_way;
  logic          wb_valid, wb_ready, fill_valid, fill_ready, fill_done;
  logic          resp_valid, resp_hit, resp_err;

  cache_eviction_controller #(.NUM_WAYS(NW), .EVICT_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_write_i(req_write), .req_ready_o(req_ready),
    .hit_way_i(hit_way), .way_valid_i(way_valid), .way_dirty_i(way_dirty),
    .eviction_target_i(ev_target), .eviction_ready_i(ev_ready),
    .access_way_o(access_way), .alloc_way_o(alloc_way),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_way_o(wb_way),
    .fill_valid_o(fill_valid), .fill_ready_i(fill_ready), .fill_done_i(fill_done),
    .resp_valid_o(resp_valid), .resp_hit_o(resp_hit), .resp_err_o(resp_err),
    .resp_way_o(resp_way)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          hit;
    logic          err;
    logic [NW-1:0] way;
    int            lat;
    int            c0;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            checks = 0, errors = 0;
  int            resp_cnt = 0, exp_resp_cnt = 0;
  int            access_cnt = 0, alloc_cnt = 0, wb_cnt = 0, wb_bad_cnt = 0, fill_cnt = 0;
  logic [NW-1:0] last_access = '0, last_alloc = '0, exp_wb_way = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every response and tracks side-band pulses
  always @(negedge clk) begin
    if (!rst) begin
      if (|access_way) begin
        access_cnt++;
        last_access = access_way;
        chk("access_onehot", $countones(access_way), 1);
        chk("pulse_exclusive", {31'd0, |alloc_way}, 0);
      end
      if (|alloc_way) begin
        alloc_cnt++;
        last_alloc = alloc_way;
        chk("alloc_onehot", $countones(alloc_way), 1);
      end
      if (wb_valid) begin
        wb_cnt++;
        if (wb_way !== exp_wb_way) wb_bad_cnt++;
      end
      if (fill_valid) fill_cnt++;
      if (resp_valid) begin
        resp_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_resp", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_hit", {31'd0, resp_hit}, {31'd0, mon_e.hit});
          chk("resp_err", {31'd0, resp_err}, {31'd0, mon_e.err});
          chk("resp_way", {24'd0, resp_way}, {24'd0, mon_e.way});
          if (mon_e.lat != 0) chk("resp_latency", cyc - mon_e.c0 + 1, mon_e.lat);
        end
      end
    end
  end

  task automatic issue(input bit expect_resp, input logic h, input logic er,
                       input logic [NW-1:0] w, input int lat);
    exp_t e;
    chk("req_ready_idle", {31'd0, req_ready}, 1);
    req_valid = 1'b1;
    req_write = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (expect_resp) begin
      e.hit = h; e.err = er; e.way = w; e.lat = lat; e.c0 = cyc;
      sb.push_back(e);
      exp_resp_cnt++;
    end
    chk("req_ready_busy", {31'd0, req_ready}, 0);
  endtask

  task automatic wait_resp(input int budget);
    int k = 0;
    while (resp_cnt < exp_resp_cnt && k < budget) begin
      @(posedge clk); k++;
    end
    if (resp_cnt < exp_resp_cnt) chk("resp_wait_expired", resp_cnt, exp_resp_cnt);
    @(posedge clk); #1;
  endtask

  initial begin
    int a0, l0, w0, f0, b0, r0, k;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    hit_way = '0; way_valid = '1; way_dirty = '0; ev_target = '0; ev_ready = 1'b0;
    wb_ready = 1'b0; fill_ready = 1'b0; fill_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_req_ready", {31'd0, req_ready}, 1);
    chk("rst_valids", {28'd0, resp_valid, wb_valid, fill_valid, resp_err}, 0);
    chk("rst_ways", {24'd0, access_way | alloc_way | wb_way | resp_way}, 0);

    // Single hit on way 2
    hit_way = 8'b0000_0100; a0 = access_cnt; l0 = alloc_cnt;
    issue(1, 1'b1, 1'b0, 8'b0000_0100, 2);
    wait_resp(20);
    chk("hit_access_way", {24'd0, last_access}, 32'h04);
    chk("hit_access_cnt", access_cnt - a0, 1);
    chk("hit_no_alloc", alloc_cnt - l0, 0);

    // Multiple hits resolve to lowest index
    hit_way = 8'b0110_1000; a0 = access_cnt;
    issue(1, 1'b1, 1'b0, 8'b0000_1000, 2);
    wait_resp(20);
    chk("multihit_access_way", {24'd0, last_access}, 32'h08);
    chk("multihit_access_cnt", access_cnt - a0, 1);
    hit_way = '0;

    // Miss with an invalid way, zero-wait fill
    way_valid = 8'b1111_0111; fill_ready = 1'b1; fill_done = 1'b1;
    a0 = access_cnt; l0 = alloc_cnt; w0 = wb_cnt; f0 = fill_cnt;
    issue(1, 1'b0, 1'b0, 8'b0000_1000, 5);
    wait_resp(20);
    chk("inv_alloc_way", {24'd0, last_alloc}, 32'h08);
    chk("inv_alloc_cnt", alloc_cnt - l0, 1);
    chk("inv_no_wb", wb_cnt - w0, 0);
    chk("inv_fill_cycles", fill_cnt - f0, 1);
    chk("inv_no_access", access_cnt - a0, 0);

    // All valid, clean policy victim available at once
    way_valid = '1; way_dirty = '0; ev_ready = 1'b1; ev_target = 8'b0000_0010;
    l0 = alloc_cnt; w0 = wb_cnt;
    issue(1, 1'b0, 1'b0, 8'b0000_0010, 5);
    wait_resp(20);
    chk("clean_alloc_way", {24'd0, last_alloc}, 32'h02);
    chk("clean_no_wb", wb_cnt - w0, 0);

    // Dirty victim: ready with a zero target first, then way 7 after 3 cycles
    way_dirty = 8'b1000_0000; ev_target = '0; exp_wb_way = 8'b1000_0000;
    l0 = alloc_cnt; w0 = wb_cnt; b0 = wb_bad_cnt; f0 = fill_cnt;
    issue(1, 1'b0, 1'b0, 8'b1000_0000, 0);
    repeat (3) @(posedge clk);
    #1 ev_target = 8'b1000_0000;
    k = 0;
    while (!wb_valid && k < 50) begin @(negedge clk); k++; end
    chk("dirty_wb_seen", {31'd0, wb_valid}, 1);
    repeat (4) @(negedge clk);
    wb_ready = 1'b1;
    @(posedge clk); #1 wb_ready = 1'b0;
    wait_resp(40);
    chk("dirty_wb_cycles", wb_cnt - w0, 5);
    chk("dirty_wb_way_stable", wb_bad_cnt - b0, 0);
    chk("dirty_alloc_way", {24'd0, last_alloc}, 32'h80);
    chk("dirty_fill_cycles", fill_cnt - f0, 1);
    ev_ready = 1'b0; ev_target = '0; way_dirty = '0; exp_wb_way = '0;

    // Slow fill: early fill_done ignored, done two cycles after the handshake
    way_valid = 8'b0111_1111; fill_ready = 1'b0; fill_done = 1'b1; f0 = fill_cnt;
    issue(1, 1'b0, 1'b0, 8'b1000_0000, 8);
    repeat (3) @(posedge clk);
    #1 begin fill_ready = 1'b1; fill_done = 1'b0; end
    @(posedge clk); #1 fill_ready = 1'b0;
    @(posedge clk); #1 fill_done = 1'b1;
    @(posedge clk); #1 fill_done = 1'b0;
    wait_resp(20);
    chk("slowfill_fill_cycles", fill_cnt - f0, 2);
    chk("slowfill_alloc_way", {24'd0, last_alloc}, 32'h80);

    // Reset while a fill request is outstanding
    way_valid = 8'b1111_1110; fill_ready = 1'b0; fill_done = 1'b0; r0 = resp_cnt;
    issue(0, 1'b0, 1'b0, '0, 0);
    k = 0;
    while (!fill_valid && k < 20) begin @(negedge clk); k++; end
    chk("midfill_fill_valid", {31'd0, fill_valid}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midfill_req_ready", {31'd0, req_ready}, 1);
    chk("midfill_fill_clear", {31'd0, fill_valid}, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("midfill_no_resp", resp_cnt - r0, 0);

    // Policy never ready with all ways valid
    way_valid = '1; ev_ready = 1'b0; l0 = alloc_cnt; r0 = resp_cnt;
`ifdef EVICT_TIMEOUT_EN
    issue(1, 1'b0, 1'b1, '0, TMO + 2);
    wait_resp(200);
    chk("timeout_no_alloc", alloc_cnt - l0, 0);
`else
    issue(0, 1'b0, 1'b0, '0, 0);
    repeat (1000) @(posedge clk);
    #1;
    chk("notimeout_no_resp", resp_cnt - r0, 0);
    chk("notimeout_still_busy", {31'd0, req_ready}, 0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("notimeout_recover", {31'd0, req_ready}, 1);
`endif

    // Controller still serves hits afterwards
    hit_way = 8'b0000_0001;
    issue(1, 1'b1, 1'b0, 8'b0000_0001, 2);
    wait_resp(20);
    hit_way = '0;
    chk("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_eviction_controller.md
CACHE_EVICTION_CONTROLLER -- requirements
Module: cache_eviction_controller

Interface
REQ-001 Parameter NUM_WAYS, default 8, number of ways in the set; power of two, 2..512.
REQ-002 Parameter EVICT_TIMEOUT, default 64, cycles to wait for eviction_ready before abort (REQ-030).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 req_valid, req_write  input  1, 1  lookup request and its type; req_ready  output  1  controller accepts request.
REQ-006 hit_way  input  NUM_WAYS  one-hot tag-match vector, valid in LOOKUP.
REQ-007 way_valid, way_dirty  input  NUM_WAYS, NUM_WAYS  per-way state bits.
REQ-008 eviction_target  input  NUM_WAYS  one-hot victim from the eviction policy; eviction_ready  input  1  target valid.
REQ-009 access_way  output  NUM_WAYS  one-cycle one-hot pulse to the policy for a hit; alloc_way  output  NUM_WAYS  one-cycle one-hot pulse for an allocation.
REQ-010 wb_valid  output  1, wb_ready  input  1, wb_way  output  NUM_WAYS  dirty-victim writeback handshake.
REQ-011 fill_valid  output  1, fill_ready  input  1, fill_done  input  1  line-fill request handshake plus completion pulse.
REQ-012 resp_valid  output  1, resp_hit  output  1, resp_err  output  1, resp_way  output  NUM_WAYS  one-cycle response.

Function
REQ-013 FSM states: IDLE, LOOKUP, SELECT, WRITEBACK, FILL, ALLOC, RESP; state register encoded in 3 bits.
REQ-014 IDLE: req_ready=1; req_valid&req_ready captures req_write and moves to LOOKUP next cycle.
REQ-015 LOOKUP (1 cycle): hit_way!=0 -> latch hit_way, pulse access_way=hit_way, go RESP with resp_hit=1; else go SELECT.
REQ-016 LOOKUP with more than one hit_way bit set: lowest-index bit is used.
REQ-017 SELECT: any way_valid bit clear -> victim = lowest-index invalid way, same cycle, no policy wait.
REQ-018 SELECT, all ways valid: wait for eviction_ready=1, latch eviction_target as victim; eviction_target=0 while ready is treated as not ready.
REQ-019 Victim dirty (way_dirty[victim]=1 and way_valid[victim]=1) -> WRITEBACK; else -> FILL.
REQ-020 WRITEBACK: wb_valid=1, wb_way=victim held stable until wb_valid&wb_ready; then FILL.
REQ-021 FILL: fill_valid=1 until fill_valid&fill_ready, then deasserted; stay in FILL until fill_done; fill_done in the same cycle as the handshake counts.
REQ-022 fill_done before the fill handshake is ignored.
REQ-023 ALLOC (1 cycle): pulse alloc_way=victim, then RESP.
REQ-024 RESP (1 cycle): resp_valid=1, resp_way=latched way, resp_hit/resp_err per path; then IDLE.
REQ-025 Miss latency with invalid way, zero-wait memory: request accept to resp_valid = 5 cycles (LOOKUP, SELECT, FILL, ALLOC, RESP); hit = 2 cycles.
REQ-026 access_way and alloc_way never asserted in the same cycle; each at most one bit set.
REQ-027 req_ready=0 in every state other than IDLE; no request queuing.

Reset
REQ-028 rst=1 at any edge, including mid-WRITEBACK or mid-FILL, forces IDLE next cycle and abandons the transaction without a response.
REQ-029 Reset values: req_ready=1 after release, all other outputs 0, victim/latched way 0, timeout counter 0.

Configuration
REQ-030 With EVICT_TIMEOUT_EN defined: a counter clears on SELECT entry and increments each cycle waiting on eviction_ready; at EVICT_TIMEOUT it jumps to RESP with resp_err=1, resp_hit=0, resp_way=0, no alloc_way pulse.
REQ-031 Without EVICT_TIMEOUT_EN: SELECT waits indefinitely; resp_err tied 0; no counter logic.

Verification
REQ-032 Hit: hit_way=8'b0000_0100 in LOOKUP -> access_way=8'b0000_0100 pulse, resp_valid 2 cycles after accept, resp_hit=1.
REQ-033 Invalid-way miss: way_valid=8'b1111_0111, hit_way=0, fill_ready=1, fill_done=1 immediately -> alloc_way=8'b0000_1000, resp 5 cycles after accept, no wb_valid.
REQ-034 Dirty eviction: all valid, eviction_target=8'b1000_0000 after 3 cycles, way_dirty[7]=1, wb_ready delayed 4 cycles -> wb_way held 8'b1000_0000 for 5 cycles, then fill, alloc_way=8'b1000_0000.
REQ-035 Timeout (macro on, EVICT_TIMEOUT=64): all valid, eviction_ready=0 -> resp_err=1 exactly 64 cycles after SELECT entry; macro off -> no response after 1000 cycles.
REQ-036 Reset mid-FILL: rst=1 while fill_valid=1 -> next cycle IDLE, req_ready=1, fill_valid=0, no resp_valid.
